// File: rtl/ncpu32k_irq_sched.sv
// Interrupt scheduler: picks the highest-priority masked pending IRQ (lowest
// index wins), offers its vector to the core with a valid/ack handshake,
// tracks the single in-service IRQ until EOI, and counts withdrawn offers.
module ncpu32k_irq_sched #(
  parameter int NIRQ = 32,
  parameter int IDW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq_pend_i,
  input  logic            intr_en_i,
  output logic            req_valid_o,
  output logic [IDW-1:0]  req_vec_o,
  input  logic            req_ack_i,
  input  logic            eoi_i,
  output logic [NIRQ-1:0] isr_o,
  output logic            busy_o,
  output logic [7:0]      spur_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_OFFER,
    S_SERVICE
  } state_t;

  state_t          state_q, state_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic            req_valid_q, req_valid_d;
  logic [IDW-1:0]  req_vec_q, req_vec_d;
  logic [NIRQ-1:0] isr_q, isr_d;
  logic            busy_q, busy_d;
  logic [7:0]      spur_cnt_q, spur_cnt_d;

  logic [IDW-1:0]  arb_vec;
  logic [NIRQ-1:0] vec_oh;
  logic            vec_still_pend;

  // Fixed-priority encoder over the snapshot; scanning downward lets the
  // lowest set index overwrite any higher one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    arb_vec = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pend_q[i]) arb_vec = IDW'(i);
    end
  end

  // One-hot of the offered vector; only indices below NIRQ can ever match,
  // so unused upper vector values never address a line.
  always_comb begin
    vec_oh = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (req_vec_q == IDW'(i)) vec_oh[i] = 1'b1;
    end
    vec_still_pend = |(irq_pend_i & vec_oh);
  end

  // Next-state and registered-output logic of the scheduler FSM.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    req_valid_d = req_valid_q;
    req_vec_d   = req_vec_q;
    isr_d       = isr_q;
    spur_cnt_d  = spur_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (intr_en_i && (|irq_pend_i)) begin
          pend_d  = irq_pend_i;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        req_vec_d   = arb_vec;
        req_valid_d = 1'b1;
        state_d     = S_OFFER;
      end
      S_OFFER: begin
        // Ack takes precedence over a simultaneous withdraw condition.
        if (req_ack_i) begin
          isr_d       = vec_oh;
          req_valid_d = 1'b0;
          state_d     = S_SERVICE;
        end else if (!vec_still_pend || !intr_en_i) begin
          req_valid_d = 1'b0;
          if (spur_cnt_q != 8'hFF) spur_cnt_d = spur_cnt_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eoi_i) begin
          isr_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      req_valid_q <= 1'b0;
      req_vec_q   <= '0;
      isr_q       <= '0;
      busy_q      <= 1'b0;
      spur_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      req_valid_q <= req_valid_d;
      req_vec_q   <= req_vec_d;
      isr_q       <= isr_d;
      busy_q      <= busy_d;
      spur_cnt_q  <= spur_cnt_d;
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_vec_o   = req_vec_q;
  assign isr_o       = isr_q;
  assign busy_o      = busy_q;
  assign spur_cnt_o  = spur_cnt_q;

endmodule

// File: tb/tb_ncpu32k_irq_sched.sv
// Self-checking bench for ncpu32k_irq_sched: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_ncpu32k_irq_sched;
  localparam int NIRQ = 32;
  localparam int IDW  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [NIRQ-1:0] irq_pend_i;
  logic            intr_en_i;
  logic            req_valid_o;
  logic [IDW-1:0]  req_vec_o;
  logic            req_ack_i;
  logic            eoi_i;
  logic [NIRQ-1:0] isr_o;
  logic            busy_o;
  logic [7:0]      spur_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  // Reference model: an offer in flight, a scheduled offer one cycle away,
  // the in-service IRQ number (-1 = none) and the withdraw count.
  bit m_valid;
  int m_vec;
  bit m_arb;
  int m_sched;
  int m_isv;
  int m_spur;

  ncpu32k_irq_sched #(.NIRQ(NIRQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_pend_i (irq_pend_i),
    .intr_en_i  (intr_en_i),
    .req_valid_o(req_valid_o),
    .req_vec_o  (req_vec_o),
    .req_ack_i  (req_ack_i),
    .eoi_i      (eoi_i),
    .isr_o      (isr_o),
    .busy_o     (busy_o),
    .spur_cnt_o (spur_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, got, exp);
    end
  endtask

  function automatic int lowest_set(input logic [NIRQ-1:0] v);
    for (int i = 0; i < NIRQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    if (rst) begin
      m_valid = 0; m_vec = 0; m_arb = 0; m_sched = 0; m_isv = -1; m_spur = 0;
    end else if (m_valid) begin
      if (req_ack_i) begin
        m_isv   = m_vec;
        m_valid = 0;
      end else if (!irq_pend_i[m_vec] || !intr_en_i) begin
        m_valid = 0;
        if (m_spur < 255) m_spur++;
      end
    end else if (m_isv >= 0) begin
      if (eoi_i) m_isv = -1;
    end else if (m_arb) begin
      m_arb   = 0;
      m_valid = 1;
      m_vec   = m_sched;
    end else if (intr_en_i && irq_pend_i != '0) begin
      m_arb   = 1;
      m_sched = lowest_set(irq_pend_i);
    end
  endtask

  task automatic compare_all();
    logic [NIRQ-1:0] e_isr;
    e_isr = '0;
    if (m_isv >= 0) e_isr[m_isv] = 1'b1;
    check("valid", 32'(req_valid_o), 32'(m_valid));
    check("vec",   32'(req_vec_o),   32'(m_vec));
    check("isr",   32'(isr_o),       32'(e_isr));
    check("busy",  32'(busy_o),      32'(m_arb || m_valid || (m_isv >= 0)));
    check("spur",  32'(spur_cnt_o),  32'(m_spur));
  endtask

  // One clock: update the model, let the edge happen, sample 1 time unit later.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    cycle++;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 0; irq_pend_i = '0; intr_en_i = 1; req_ack_i = 0; eoi_i = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_isv = -1;
    #2;
    cyc();
    rst = 0;
    cyc();

    // Reset in the middle of an offer of vector 3.
    irq_pend_i = 32'h8; cyc(); cyc();
    check("t1_offer_vec3", 32'(req_vec_o), 32'd3);
    rst = 1; cyc();
    check("t1_rst_valid", 32'(req_valid_o), 32'd0);
    check("t1_rst_busy",  32'(busy_o),      32'd0);
    idle_inputs(); cyc();

    // Priority: lowest index of 0x14 wins, then level source re-offered after EOI.
    irq_pend_i = 32'h14; cyc();
    check("t2_not_yet", 32'(req_valid_o), 32'd0);
    cyc();
    check("t2_valid_t2", 32'(req_valid_o), 32'd1);
    check("t2_vec2",     32'(req_vec_o),   32'd2);
    req_ack_i = 1; cyc(); req_ack_i = 0;
    check("t2_isr", 32'(isr_o), 32'h4);
    cyc();
    irq_pend_i = 32'h10; eoi_i = 1; cyc(); eoi_i = 0;
    cyc();
    check("t2_eoi_plus2", 32'(req_valid_o), 32'd0);
    cyc();
    check("t2_eoi_plus3", 32'(req_valid_o), 32'd1);
    check("t2_vec4",      32'(req_vec_o),   32'd4);
    req_ack_i = 1; cyc(); req_ack_i = 0; irq_pend_i = '0;
    eoi_i = 1; cyc(); eoi_i = 0; cyc();

    // Withdraw before ack.
    irq_pend_i = 32'h1; cyc(); cyc();
    irq_pend_i = '0; cyc();
    check("t3_withdrawn", 32'(req_valid_o), 32'd0);
    check("t3_spur",      32'(spur_cnt_o),  32'd1);
    cyc();

    // Ack races with enable dropping: ack wins.
    irq_pend_i = 32'h80; cyc(); cyc();
    req_ack_i = 1; intr_en_i = 0; cyc();
    req_ack_i = 0; intr_en_i = 1; irq_pend_i = '0;
    check("t4_isr",  32'(isr_o),      32'h80);
    check("t4_spur", 32'(spur_cnt_o), 32'd1);
    eoi_i = 1; cyc(); eoi_i = 0; cyc();

    // Hold: a higher-priority arrival does not change the offer; SERVICE ignores pends.
    irq_pend_i = 32'h20; cyc(); cyc();
    irq_pend_i = 32'h22; cyc(); cyc(); cyc();
    check("t5_hold_vec", 32'(req_vec_o), 32'd5);
    req_ack_i = 1; cyc(); req_ack_i = 0;
    irq_pend_i = 32'hFF;
    for (int i = 0; i < 5; i++) cyc();
    check("t5_no_offer_in_service", 32'(req_valid_o), 32'd0);
    irq_pend_i = '0; eoi_i = 1; cyc(); eoi_i = 0; cyc();

    // Saturation of the withdraw counter.
    for (int i = 0; i < 300; i++) begin
      irq_pend_i = 32'h1; cyc(); cyc();
      irq_pend_i = '0; cyc();
    end
    check("t6_spur_sat", 32'(spur_cnt_o), 32'd255);

    // Stray EOI/ack while idle.
    intr_en_i = 0; eoi_i = 1; req_ack_i = 1;
    for (int i = 0; i < 4; i++) cyc();
    check("t6_stray_busy", 32'(busy_o), 32'd0);
    idle_inputs();
    rst = 1; cyc(); rst = 0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) irq_pend_i = $urandom & $urandom & $urandom;
      intr_en_i = ($urandom_range(0, 9) != 0);
      req_ack_i = ($urandom_range(0, 3) == 0);
      eoi_i     = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
